// File: rtl/convolution_ctrl_if.sv
// Control bus between convolution_ctrl and the X/Y/Z memories plus MAC datapath.
// master: controller side (start/sizes in; addresses, strobes, status out).
interface convolution_ctrl_if #(
   parameter int ADDRWIDTH  = 5,
   parameter int ZADDRWIDTH = ADDRWIDTH + 1
);
   logic                  start_i;
   logic [ADDRWIDTH-1:0]  sizeX_i;
   logic [ADDRWIDTH-1:0]  sizeY_i;
   logic                  busy_o;
   logic                  done_o;
   logic [ADDRWIDTH-1:0]  addrX_o;
   logic [ADDRWIDTH-1:0]  addrY_o;
   logic                  acc_en_o;
   logic                  acc_clr_o;
   logic [ZADDRWIDTH-1:0] addrZ_o;
   logic                  z_we_o;

   modport master (
      input  start_i, sizeX_i, sizeY_i,
      output busy_o, done_o, addrX_o, addrY_o,
      output acc_en_o, acc_clr_o, addrZ_o, z_we_o
   );

   modport slave (
      output start_i, sizeX_i, sizeY_i,
      input  busy_o, done_o, addrX_o, addrY_o,
      input  acc_en_o, acc_clr_o, addrZ_o, z_we_o
   );
endinterface

// File: rtl/convolution_ctrl.sv
// Convolution sequencer: walks output i / tap j, drives X/Y read addresses,
// accumulator enable/clear and Z write strobe. Ports: clk, rstn (async low),
// bus (convolution_ctrl_if.master). Macro CONV_TAP_SKIP_EN limits j to valid taps.
module convolution_ctrl #(
   parameter int ADDRWIDTH  = 5,
   parameter int ZADDRWIDTH = ADDRWIDTH + 1
) (
   input  logic clk,
   input  logic rstn,
   convolution_ctrl_if.master bus
);

   localparam int IW = ZADDRWIDTH + 1;
   localparam logic signed [IW-1:0] ZERO = '0;
   localparam logic signed [IW-1:0] ONE  = IW'(1);
   localparam logic signed [IW-1:0] TWO  = IW'(2);

   typedef enum logic [2:0] {
      IDLE, LOAD, MAC, DRAIN, WRITE, DONE
   } state_t;

   state_t state_q, state_d;

   logic signed [IW-1:0] i_q, i_d;
   logic signed [IW-1:0] j_q, j_d;
   logic signed [IW-1:0] sx_q, sx_d;
   logic signed [IW-1:0] sy_q, sy_d;
   logic                 first_q, first_d;
   logic                 acc_en_q, acc_en_d;
   logic                 acc_clr_q, acc_clr_d;
   logic [ADDRWIDTH-1:0] ax_q, ax_d;
   logic [ADDRWIDTH-1:0] ay_q, ay_d;

   logic signed [IW-1:0] diff;
   logic signed [IW-1:0] last_tap;
   logic signed [IW-1:0] next_first;
   logic signed [IW-1:0] z_last;
   logic                 v0;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= IDLE;
         i_q       <= '0;
         j_q       <= '0;
         sx_q      <= '0;
         sy_q      <= '0;
         first_q   <= 1'b0;
         acc_en_q  <= 1'b0;
         acc_clr_q <= 1'b0;
         ax_q      <= '0;
         ay_q      <= '0;
      end else begin
         state_q   <= state_d;
         i_q       <= i_d;
         j_q       <= j_d;
         sx_q      <= sx_d;
         sy_q      <= sy_d;
         first_q   <= first_d;
         acc_en_q  <= acc_en_d;
         acc_clr_q <= acc_clr_d;
         ax_q      <= ax_d;
         ay_q      <= ay_d;
      end
   end

   always_comb begin
      diff   = i_q - j_q;
      v0     = (diff >= ZERO) && (diff < sx_q);
      z_last = sx_q + sy_q - TWO;
`ifdef CONV_TAP_SKIP_EN
      // Tap window for output i: max(0, i-sx+1) .. min(i, sy-1).
      last_tap   = (i_q < sy_q - ONE) ? i_q : (sy_q - ONE);
      next_first = i_q + TWO - sx_q;
      if (next_first < ZERO) next_first = ZERO;
`else
      last_tap   = sy_q - ONE;
      next_first = ZERO;
`endif
   end

   always_comb begin
      state_d   = state_q;
      i_d       = i_q;
      j_d       = j_q;
      sx_d      = sx_q;
      sy_d      = sy_q;
      first_d   = first_q;
      ax_d      = ax_q;
      ay_d      = ay_q;
      acc_en_d  = 1'b0;
      acc_clr_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.start_i) state_d = LOAD;
         end
         LOAD: begin
            sx_d    = IW'(bus.sizeX_i);
            sy_d    = IW'(bus.sizeY_i);
            i_d     = ZERO;
            j_d     = ZERO;
            first_d = 1'b1;
            if (bus.sizeX_i == '0 || bus.sizeY_i == '0)
               state_d = DONE;
            else
               state_d = MAC;
         end
         MAC: begin
            ax_d      = diff[ADDRWIDTH-1:0];
            ay_d      = j_q[ADDRWIDTH-1:0];
            // Both land one cycle later, alongside the read data.
            acc_en_d  = v0;
            acc_clr_d = first_q;
            first_d   = 1'b0;
            if (j_q == last_tap)
               state_d = DRAIN;
            else
               j_d = j_q + ONE;
         end
         DRAIN: begin
            state_d = WRITE;
         end
         WRITE: begin
            if (i_q == z_last) begin
               state_d = DONE;
            end else begin
               i_d     = i_q + ONE;
               j_d     = next_first;
               first_d = 1'b1;
               state_d = MAC;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.busy_o    = (state_q != IDLE);
   assign bus.done_o    = (state_q == DONE);
   assign bus.addrX_o   = (state_q == MAC) ? diff[ADDRWIDTH-1:0] : ax_q;
   assign bus.addrY_o   = (state_q == MAC) ? j_q[ADDRWIDTH-1:0] : ay_q;
   assign bus.acc_en_o  = acc_en_q;
   assign bus.acc_clr_o = acc_clr_q;
   assign bus.z_we_o    = (state_q == WRITE);
   assign bus.addrZ_o   = i_q[ZADDRWIDTH-1:0];

endmodule

// File: tb/tb_convolution_ctrl.sv
// Directed bench for convolution_ctrl with X/Y memory, accumulator and Z model.
// Tasks per scenario; one summary line at the end.
module tb_convolution_ctrl;

`ifdef CONV_TAP_SKIP_EN
   localparam int EXP_DONE  = 26;
   localparam int EXP_CLR2  = 6;
   localparam int EXP_DONE2 = 12;
`else
   localparam int EXP_DONE  = 32;
   localparam int EXP_CLR2  = 8;
   localparam int EXP_DONE2 = 14;
`endif

   logic clk  = 1'b0;
   logic rstn = 1'b0;

   convolution_ctrl_if #(.ADDRWIDTH(5)) bus ();

   convolution_ctrl #(.ADDRWIDTH(5)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   int xmem [32];
   int ymem [32];
   int zmem [64];
   int xr   = 0;
   int yr   = 0;
   int acc  = 0;

   int cyc     = 0;
   int en_n    = 0;
   int clr_n   = 0;
   int zw_n    = 0;
   int busy_n  = 0;
   int clr_cyc [256];
   int zlog    [256];

   int t0   = 0;
   int lowb = 0;

   // Synchronous-read memories, accumulator with clear mux, Z memory.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      xr  <= xmem[bus.addrX_o];
      yr  <= ymem[bus.addrY_o];
      if (bus.acc_en_o || bus.acc_clr_o)
         acc <= (bus.acc_clr_o ? 0 : acc) + (bus.acc_en_o ? xr * yr : 0);
      if (bus.z_we_o)
         zmem[bus.addrZ_o] <= acc;
   end

   always @(negedge clk) begin
      if (bus.acc_en_o) en_n++;
      if (bus.acc_clr_o) begin
         clr_cyc[clr_n % 256] = cyc;
         clr_n++;
      end
      if (bus.z_we_o) begin
         zlog[zw_n % 256] = int'(bus.addrZ_o);
         zw_n++;
      end
      if (bus.busy_o) busy_n++;
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic fill(input int x0, x1, x2, x3, y0, y1, y2);
      for (int k = 0; k < 32; k++) begin
         xmem[k] = 100;
         ymem[k] = 100;
      end
      xmem[0] = x0; xmem[1] = x1; xmem[2] = x2; xmem[3] = x3;
      ymem[0] = y0; ymem[1] = y1; ymem[2] = y2;
   endtask

   task automatic run(input int sx, input int sy, input bit spam,
                      output int dcyc);
      logic [4:0] sx5, sy5;
      sx5 = sx[4:0];
      sy5 = sy[4:0];
      step();
      bus.sizeX_i = sx5;
      bus.sizeY_i = sy5;
      bus.start_i = 1'b1;
      t0 = cyc;
      step();
      bus.start_i = 1'b0;
      lowb = 0;
      dcyc = -1;
      for (int k = 0; k < 400; k++) begin
         if (bus.done_o) begin
            dcyc = cyc - t0;
            break;
         end
         if (!bus.busy_o) lowb++;
         bus.start_i = spam && (k % 3 == 0);
         step();
      end
      bus.start_i = 1'b0;
      if (dcyc < 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL run_timeout: done_o not seen in 400 cycles");
      end
   endtask

   task automatic test_reset();
      step();
      n_cmp++;
      if ({bus.busy_o, bus.done_o, bus.acc_en_o, bus.acc_clr_o,
           bus.z_we_o} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_flags: got %b want 00000",
                  {bus.busy_o, bus.done_o, bus.acc_en_o, bus.acc_clr_o,
                   bus.z_we_o});
      end
      n_cmp++;
      if ({bus.addrX_o, bus.addrY_o, bus.addrZ_o} !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_addr: got %h want 0000",
                  {bus.addrX_o, bus.addrY_o, bus.addrZ_o});
      end
      rstn = 1'b1;
      step();
   endtask

   task automatic test_idle();
      int b0, e0, z0;
      b0 = busy_n; e0 = en_n + clr_n; z0 = zw_n;
      for (int k = 0; k < 20; k++) step();
      n_cmp++;
      if (busy_n - b0 !== 0) begin
         n_fail++;
         $display("FAIL idle_busy: got %0d busy cycles want 0", busy_n - b0);
      end
      n_cmp++;
      if ((en_n + clr_n - e0) !== 0 || (zw_n - z0) !== 0) begin
         n_fail++;
         $display("FAIL idle_activity: got en/clr %0d zw %0d want 0 0",
                  en_n + clr_n - e0, zw_n - z0);
      end
   endtask

   task automatic test_main_run();
      int z0, e0, c0, d;
      int zexp [6];
      zexp = '{1, 3, 6, 9, 7, 4};
      fill(1, 2, 3, 4, 1, 1, 1);
      z0 = zw_n; e0 = en_n; c0 = clr_n;
      run(4, 3, 1'b0, d);
      n_cmp++;
      if (d !== EXP_DONE) begin
         n_fail++;
         $display("FAIL main_done_cycle: got %0d want %0d", d, EXP_DONE);
      end
      n_cmp++;
      if (lowb !== 0) begin
         n_fail++;
         $display("FAIL main_busy: got %0d low cycles want 0", lowb);
      end
      n_cmp++;
      if (zw_n - z0 !== 6) begin
         n_fail++;
         $display("FAIL main_zw_count: got %0d want 6", zw_n - z0);
      end
      for (int k = 0; k < 6; k++) begin
         n_cmp++;
         if (zmem[k] !== zexp[k] || zlog[(z0 + k) % 256] !== k) begin
            n_fail++;
            $display("FAIL main_z%0d: got data %0d addr %0d want %0d %0d",
                     k, zmem[k], zlog[(z0 + k) % 256], zexp[k], k);
         end
      end
      n_cmp++;
      if (en_n - e0 !== 12) begin
         n_fail++;
         $display("FAIL main_en_count: got %0d want 12", en_n - e0);
      end
      n_cmp++;
      if (clr_n - c0 !== 6) begin
         n_fail++;
         $display("FAIL main_clr_count: got %0d want 6", clr_n - c0);
      end
      n_cmp++;
      if (clr_cyc[c0 % 256] - t0 !== 3 ||
          clr_cyc[(c0 + 1) % 256] - t0 !== EXP_CLR2) begin
         n_fail++;
         $display("FAIL main_clr_timing: got %0d %0d want 3 %0d",
                  clr_cyc[c0 % 256] - t0, clr_cyc[(c0 + 1) % 256] - t0,
                  EXP_CLR2);
      end
      step();
      n_cmp++;
      if ({bus.busy_o, bus.done_o} !== 2'b00) begin
         n_fail++;
         $display("FAIL main_after_idle: got %b want 00",
                  {bus.busy_o, bus.done_o});
      end
   endtask

   task automatic test_zero_size();
      int z0, e0, c0, d;
      int szx [2];
      int szy [2];
      szx = '{0, 3};
      szy = '{3, 0};
      for (int k = 0; k < 2; k++) begin
         z0 = zw_n; e0 = en_n; c0 = clr_n;
         run(szx[k], szy[k], 1'b0, d);
         n_cmp++;
         if (d !== 2) begin
            n_fail++;
            $display("FAIL zero%0d_done_cycle: got %0d want 2", k, d);
         end
         n_cmp++;
         if (zw_n - z0 !== 0 || en_n - e0 !== 0 || clr_n - c0 !== 0) begin
            n_fail++;
            $display("FAIL zero%0d_activity: got zw %0d en %0d clr %0d want 0",
                     k, zw_n - z0, en_n - e0, clr_n - c0);
         end
         step();
      end
   endtask

   task automatic test_reset_midrun();
      int z0, d;
      bit hit;
      fill(1, 2, 3, 4, 1, 1, 1);
      z0 = zw_n;
      step();
      bus.sizeX_i = 5'd4;
      bus.sizeY_i = 5'd3;
      bus.start_i = 1'b1;
      step();
      bus.start_i = 1'b0;
      hit = 1'b0;
      for (int k = 0; k < 100; k++) begin
         if (zw_n - z0 == 2) begin
            hit = 1'b1;
            break;
         end
         step();
      end
      if (!hit) begin
         n_cmp++;
         n_fail++;
         $display("FAIL midrun_timeout: second write not seen");
      end
      step();
      step();
      rstn = 1'b0;
      #1;
      n_cmp++;
      if ({bus.busy_o, bus.done_o, bus.acc_en_o, bus.acc_clr_o,
           bus.z_we_o, bus.addrX_o, bus.addrY_o, bus.addrZ_o} !== 21'h0) begin
         n_fail++;
         $display("FAIL midrun_reset_outputs: got %h want 0",
                  {bus.busy_o, bus.done_o, bus.acc_en_o, bus.acc_clr_o,
                   bus.z_we_o, bus.addrX_o, bus.addrY_o, bus.addrZ_o});
      end
      step();
      step();
      step();
      n_cmp++;
      if (zw_n - z0 !== 2) begin
         n_fail++;
         $display("FAIL midrun_writes: got %0d want 2", zw_n - z0);
      end
      rstn = 1'b1;
      step();
      fill(2, 3, 100, 100, 4, 5, 100);
      z0 = zw_n;
      run(2, 2, 1'b1, d);
      n_cmp++;
      if (d !== EXP_DONE2) begin
         n_fail++;
         $display("FAIL restart_done_cycle: got %0d want %0d", d, EXP_DONE2);
      end
      n_cmp++;
      if (zmem[0] !== 8 || zmem[1] !== 22 || zmem[2] !== 15) begin
         n_fail++;
         $display("FAIL restart_z: got %0d %0d %0d want 8 22 15",
                  zmem[0], zmem[1], zmem[2]);
      end
      n_cmp++;
      if (zw_n - z0 !== 3) begin
         n_fail++;
         $display("FAIL restart_zw_count: got %0d want 3", zw_n - z0);
      end
      step();
      step();
      step();
      n_cmp++;
      if (bus.busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL restart_spam_ignored: busy %b want 0", bus.busy_o);
      end
   endtask

   initial begin
      bus.start_i = 1'b0;
      bus.sizeX_i = '0;
      bus.sizeY_i = '0;
      for (int k = 0; k < 64; k++) zmem[k] = -1;
      test_reset();
      test_idle();
      test_main_run();
      test_zero_size();
      test_reset_midrun();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/convolution_ctrl.md
Name: convolution_ctrl

Overview:
Sequencing/address-generation stage that drives the convolution multiply-accumulate datapath directly downstream of it. It computes a full linear convolution Z[i] = sum_j X[i-j]*Y[j] for i = 0..sizeX+sizeY-2. It walks output index i and tap index j, issues read addresses to the synchronous-read X/Y memories, and drives the accumulator's enable plus a clear-select for its feedback mux. It also issues the Z-memory write strobe/address when each output is complete.

Parameters:
ADDRWIDTH, 5, width of X/Y addresses and of sizeX_i/sizeY_i; max length 2^ADDRWIDTH-1
ZADDRWIDTH, ADDRWIDTH+1, width of Z address (output length up to 2*(2^ADDRWIDTH-1)-1)

Ports:
clk  in  1  clock, rising edge
rstn  in  1  reset, asynchronous, active-low
start_i  in  1  start request; sampled only in IDLE
sizeX_i  in  ADDRWIDTH  length of X; latched in LOAD
sizeY_i  in  ADDRWIDTH  length of Y; latched in LOAD
busy_o  out  1  high in every state except IDLE
done_o  out  1  one-cycle pulse in DONE
addrX_o  out  ADDRWIDTH  X memory read address (i-j)
addrY_o  out  ADDRWIDTH  Y memory read address (j)
acc_en_o  out  1  accumulator enable, aligned with memory read data
acc_clr_o  out  1  feedback-mux select: forces accumulator dataZ_i to 0 this cycle
addrZ_o  out  ZADDRWIDTH  Z memory write address (i)
z_we_o  out  1  Z memory write strobe; data is the accumulator output

Behaviour:
- Reset: state IDLE; all outputs 0; i, j, latched sizes, pipeline regs 0. Reset mid-run aborts immediately with no further writes.
- States:
  - IDLE: start_i=1 -> LOAD.
  - LOAD: latch sizes; i=0; j=first tap. If either size = 0 -> DONE, with no writes; else -> MAC.
  - MAC: one tap per cycle; addrY_o=j, addrX_o=i-j (low ADDRWIDTH bits), tap valid v0 = (0 <= i-j < sizeX). After last tap -> DRAIN.
  - DRAIN: one cycle.
  - WRITE: z_we_o=1, addrZ_o=i. If i = sizeX+sizeY-2 -> DONE; else i++, j=first tap -> MAC.
  - DONE: done_o=1 -> IDLE.
- Memory read latency is 1 cycle. acc_en_o = v0 registered one cycle, so it is high in the cycle the data arrives at the accumulator.
- acc_clr_o is high one cycle after the first MAC cycle of each output, regardless of v0.
- Accumulator registers at the end of that cycle. The result is valid in the WRITE cycle, 2 cycles after the last MAC cycle.
- Per output: taps + 2 cycles. addrX_o/addrY_o hold their last values outside MAC. acc_en_o/acc_clr_o/z_we_o are 0 outside the aligned cycles.
- start_i while busy_o=1 is ignored. start_i held high in DONE is not accepted until the IDLE cycle (minimum 1 idle cycle between runs).
- Index arithmetic uses ZADDRWIDTH+1 signed width internally; no wrap on i-j.

Optional Feature:
CONV_TAP_SKIP_EN
- Defined: per output, j runs from max(0, i-sizeX+1) to min(i, sizeY-1), so every MAC cycle is valid. Total MAC cycles = sizeX*sizeY.
- Undefined: j runs 0..sizeY-1 for every output; out-of-range taps give acc_en_o=0. Total MAC cycles = (sizeX+sizeY-1)*sizeY.
- Z results are identical in both builds.

Test Plan:
- Reset then idle -> all outputs 0, busy_o=0; start_i=0 for 20 cycles -> no activity.
- With MAC+memory model, sizeX=4, X=[1,2,3,4], sizeY=3, Y=[1,1,1], start pulse -> Z[0..5]=[1,3,6,9,7,4]; exactly 6 z_we_o pulses at addrZ 0..5.
- Same run, timing -> done_o 32 cycles after start cycle without CONV_TAP_SKIP_EN; 26 cycles with it. busy_o high throughout.
- Every acc_clr_o cycle is exactly one cycle after an output's first MAC cycle. No acc_en_o when i-j is out of range. z_we_o count equals sizeX+sizeY-1.
- sizeX=0 or sizeY=0, start -> LOAD then DONE; done_o at cycle 2; no z_we_o, acc_en_o or acc_clr_o.
- Assert rstn=0 mid-MAC of output 2, then restart with sizeX=2 ([2,3]), sizeY=2 ([4,5]) -> outputs 0 immediately; clean run gives Z=[8,22,15]; start pulses while busy are ignored.
